// File: rtl/ir_pkg.sv
// Shared RV32I opcode constants, instruction format codes and queue entry layout.
// Included by ir_imm_gen and ir_queue; the entry is fixed to the RV32 instruction/pc layout.
package ir_pkg;

  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_REG    = 7'h33;
  localparam logic [6:0] OP_FENCE  = 7'h0F;
  localparam logic [6:0] OP_SYSTEM = 7'h73;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] isu;
  } entry_t;

endpackage

// File: rtl/ir_imm_gen.sv
// Combinational RV32I immediate/format decoder; no state, no handshake.
// Illegal-opcode detection is built only when IR_ILLEGAL_DET_EN is defined.
module ir_imm_gen
  import ir_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     isu,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic            illegal
);

  logic [31:0] imm32;
  fmt_e        fmt_d;

  always_comb begin
    imm32 = '0;
    fmt_d = FMT_R;
    case (isu[6:0])
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM, OP_FENCE: begin
        fmt_d = FMT_I;
        imm32 = {{20{isu[31]}}, isu[31:20]};
      end
      OP_STORE: begin
        fmt_d = FMT_S;
        imm32 = {{20{isu[31]}}, isu[31:25], isu[11:7]};
      end
      OP_BRANCH: begin
        fmt_d = FMT_B;
        imm32 = {{19{isu[31]}}, isu[31], isu[7], isu[30:25], isu[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        fmt_d = FMT_U;
        imm32 = {isu[31:12], 12'b0};
      end
      OP_JAL: begin
        fmt_d = FMT_J;
        imm32 = {{11{isu[31]}}, isu[31], isu[19:12], isu[20], isu[30:21], 1'b0};
      end
      default: ;
    endcase
  end

  assign imm = XLEN'($signed(imm32));
  assign fmt = fmt_d;

`ifdef IR_ILLEGAL_DET_EN
  assign illegal = (isu[1:0] != 2'b11) ||
                   !(isu[6:0] inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
                                      OP_STORE, OP_IMM, OP_REG, OP_FENCE, OP_SYSTEM});
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: rtl/ir_queue.sv
// DEPTH-entry instruction queue with field-split head decode; push visible at head next cycle.
// Full blocks pushes even when popping; flush beats push/pop. IR_ILLEGAL_DET_EN enables illegal flag.
module ir_queue
  import ir_pkg::*;
#(
  parameter int D_WIDTH      = 32,
  parameter int XLEN         = 32,
  parameter int DEPTH        = 2,
  parameter int N_REGS       = 32,
  parameter int OP_CODE_SIZE = 7,
  parameter int FUNCT_3_SIZE = 3,
  parameter int FUNCT_7_SIZE = 7,
  localparam int RF_SIZE     = $clog2(N_REGS),
  localparam int CNT_W       = $clog2(DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [D_WIDTH-1:0]      in_isu,
  input  logic [XLEN-1:0]         in_pc,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         out_pc,
  output logic [RF_SIZE-1:0]      rs1,
  output logic [RF_SIZE-1:0]      rs2,
  output logic [RF_SIZE-1:0]      rd,
  output logic [FUNCT_7_SIZE-1:0] funct7,
  output logic [FUNCT_3_SIZE-1:0] funct3,
  output logic [OP_CODE_SIZE-1:0] op_code,
  output logic [XLEN-1:0]         imm,
  output logic [2:0]              fmt,
  output logic                    illegal,
  output logic [CNT_W-1:0]        count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  entry_t             mem [DEPTH];
  logic   [PTR_W-1:0] wr_ptr;
  logic   [PTR_W-1:0] rd_ptr;
  logic               push;
  logic               pop;
  entry_t             head;

  assign in_ready  = (count != CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage is deliberately not reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push && !flush && !rst) begin
      mem[wr_ptr] <= '{pc: 32'(in_pc), isu: 32'(in_isu)};
    end
  end

  assign head = mem[rd_ptr];

  logic [XLEN-1:0] imm_raw;
  logic [2:0]      fmt_raw;
  logic            illegal_raw;

  ir_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .isu     (head.isu),
    .imm     (imm_raw),
    .fmt     (fmt_raw),
    .illegal (illegal_raw)
  );

  always_comb begin
    out_pc  = '0;
    rs1     = '0;
    rs2     = '0;
    rd      = '0;
    funct7  = '0;
    funct3  = '0;
    op_code = '0;
    imm     = '0;
    fmt     = '0;
    illegal = 1'b0;
    if (out_valid) begin
      out_pc  = XLEN'(head.pc);
      rs1     = head.isu[15 +: RF_SIZE];
      rs2     = head.isu[20 +: RF_SIZE];
      rd      = head.isu[7 +: RF_SIZE];
      funct7  = head.isu[25 +: FUNCT_7_SIZE];
      funct3  = head.isu[12 +: FUNCT_3_SIZE];
      op_code = head.isu[0 +: OP_CODE_SIZE];
      imm     = imm_raw;
      fmt     = fmt_raw;
      illegal = illegal_raw;
    end
  end

endmodule

// File: tb/tb_ir_queue.sv
// Scoreboard bench for ir_queue (DEPTH=2): decode table, full/drop, back-to-back, flush, reset.
// Expected illegal flag follows IR_ILLEGAL_DET_EN.
module tb_ir_queue;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready, illegal;
  logic [31:0] in_isu, in_pc, out_pc, imm;
  logic [4:0]  rs1, rs2, rd;
  logic [6:0]  funct7, op_code;
  logic [2:0]  funct3, fmt;
  logic [1:0]  count;

  always #5 clk = ~clk;

  ir_queue dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_isu(in_isu), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .rs1(rs1), .rs2(rs2), .rd(rd), .funct7(funct7), .funct3(funct3),
    .op_code(op_code), .imm(imm), .fmt(fmt), .illegal(illegal), .count(count)
  );

`ifdef IR_ILLEGAL_DET_EN
  localparam logic ILL_EN = 1'b1;
`else
  localparam logic ILL_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] isu;
    logic [31:0] pc;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7, op;
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  exp_t vec[9];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic test_reset;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_isu = '0; in_pc = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_tests++; if (count !== 2'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_tests++; if (out_pc !== 32'd0 || imm !== 32'd0 || fmt !== 3'd0 || rd !== 5'd0 || illegal !== 1'b0) begin
      n_fail++; $display("FAIL reset_decode: pc=%h imm=%h fmt=%0d rd=%0d ill=%b want all 0", out_pc, imm, fmt, rd, illegal);
    end
  endtask

  task automatic test_decode;
    exp_t e;
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1; in_isu = vec[i].isu; in_pc = vec[i].pc;
      sb.push_back(vec[i]);
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL dec_no_bypass[%0d]: got %b want 0", i, out_valid); end
      @(negedge clk);
      in_valid = 1'b0;
      e = sb.pop_front();
      n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL dec_valid[%0d]: got %b want 1", i, out_valid); end
      n_tests++; if (out_pc !== e.pc) begin n_fail++; $display("FAIL dec_pc[%0d]: got %h want %h", i, out_pc, e.pc); end
      n_tests++; if (rd !== e.rd) begin n_fail++; $display("FAIL dec_rd[%0d]: got %0d want %0d", i, rd, e.rd); end
      n_tests++; if (rs1 !== e.rs1) begin n_fail++; $display("FAIL dec_rs1[%0d]: got %0d want %0d", i, rs1, e.rs1); end
      n_tests++; if (rs2 !== e.rs2) begin n_fail++; $display("FAIL dec_rs2[%0d]: got %0d want %0d", i, rs2, e.rs2); end
      n_tests++; if (funct3 !== e.f3) begin n_fail++; $display("FAIL dec_f3[%0d]: got %0d want %0d", i, funct3, e.f3); end
      n_tests++; if (funct7 !== e.f7) begin n_fail++; $display("FAIL dec_f7[%0d]: got %h want %h", i, funct7, e.f7); end
      n_tests++; if (op_code !== e.op) begin n_fail++; $display("FAIL dec_op[%0d]: got %h want %h", i, op_code, e.op); end
      n_tests++; if (imm !== e.imm) begin n_fail++; $display("FAIL dec_imm[%0d]: got %h want %h", i, imm, e.imm); end
      n_tests++; if (fmt !== e.fmt) begin n_fail++; $display("FAIL dec_fmt[%0d]: got %0d want %0d", i, fmt, e.fmt); end
      n_tests++; if (illegal !== e.ill) begin n_fail++; $display("FAIL dec_illegal[%0d]: got %b want %b", i, illegal, e.ill); end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      n_tests++; if (count !== 2'd0) begin n_fail++; $display("FAIL dec_drain[%0d]: got %0d want 0", i, count); end
    end
  endtask

  task automatic test_full;
    exp_t e;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      e = '{default: '0};
      e.isu = 32'h00000013 | ((k + 1) << 7); e.pc = 32'h200 + 4 * k; e.rd = 5'(k + 1);
      in_valid = 1'b1; in_isu = e.isu; in_pc = e.pc;
      if (k < 2) sb.push_back(e);
      if (k == 2) begin
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready: got %b want 0", in_ready); end
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_tests++; if (count !== 2'd2) begin n_fail++; $display("FAIL full_count: got %0d want 2", count); end
    for (int j = 0; j < 2; j++) begin
      e = sb.pop_front();
      n_tests++; if (out_pc !== e.pc || rd !== e.rd) begin
        n_fail++; $display("FAIL full_order[%0d]: got pc=%h rd=%0d want pc=%h rd=%0d", j, out_pc, rd, e.pc, e.rd);
      end
      out_ready = 1'b1;
      @(negedge clk);
    end
    out_ready = 1'b0;
    n_tests++; if (count !== 2'd0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL full_drain: got count=%0d valid=%b want 0/0", count, out_valid);
    end
  endtask

  task automatic test_back_to_back;
    exp_t e, h;
    for (int k = 0; k < 5; k++) begin
      e = '{default: '0};
      e.isu = 32'h00000033 | ((k + 4) << 7); e.pc = 32'h300 + 4 * k; e.rd = 5'(k + 4);
      in_valid = 1'b1; in_isu = e.isu; in_pc = e.pc; out_ready = (k > 0);
      if (k > 0) begin
        h = sb.pop_front();
        n_tests++; if (out_pc !== h.pc || rd !== h.rd) begin
          n_fail++; $display("FAIL b2b_head[%0d]: got pc=%h rd=%0d want pc=%h rd=%0d", k, out_pc, rd, h.pc, h.rd);
        end
        n_tests++; if (count !== 2'd1) begin n_fail++; $display("FAIL b2b_count[%0d]: got %0d want 1", k, count); end
      end
      sb.push_back(e);
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    h = sb.pop_front();
    n_tests++; if (out_pc !== h.pc) begin n_fail++; $display("FAIL b2b_last: got %h want %h", out_pc, h.pc); end
    @(negedge clk);
    out_ready = 1'b0;
    // Fill, then offer a push while popping from full: the push must be dropped.
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; in_isu = 32'h00000013; in_pc = 32'h400 + 4 * k;
      @(negedge clk);
    end
    in_isu = 32'h00000013; in_pc = 32'h4F0; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    n_tests++; if (count !== 2'd1 || out_pc !== 32'h404) begin
      n_fail++; $display("FAIL full_pop_push: got count=%0d pc=%h want 1/00000404", count, out_pc);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL full_pop_drop: got valid=%b pc=%h want 0", out_valid, out_pc); end
  endtask

  task automatic test_flush;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; in_isu = vec[k].isu; in_pc = vec[k].pc;
      @(negedge clk);
    end
    flush = 1'b1; out_ready = 1'b1; in_isu = vec[4].isu; in_pc = 32'h500;
    @(negedge clk);
    flush = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
    n_tests++; if (count !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL flush_full: got count=%0d valid=%b rdy=%b want 0/0/1", count, out_valid, in_ready);
    end
    n_tests++; if (out_pc !== 0 || imm !== 0 || fmt !== 0 || rd !== 0 || rs1 !== 0 || op_code !== 0 || illegal !== 0) begin
      n_fail++; $display("FAIL flush_decode: got pc=%h imm=%h fmt=%0d rd=%0d op=%h want all 0", out_pc, imm, fmt, rd, op_code);
    end
    // Flush on a one-entry queue with a concurrent push: the push is discarded too.
    in_valid = 1'b1; in_isu = vec[0].isu; in_pc = 32'h600;
    @(negedge clk);
    flush = 1'b1; in_pc = 32'h604;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    n_tests++; if (count !== 2'd0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_push: got count=%0d valid=%b want 0/0", count, out_valid);
    end
    sb.delete();
  endtask

  task automatic test_reset_mid;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; in_isu = vec[1].isu; in_pc = 32'h700 + 4 * k;
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    n_tests++; if (count !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL mid_reset: got count=%0d valid=%b rdy=%b want 0/0/1", count, out_valid, in_ready);
    end
    in_valid = 1'b1; in_isu = vec[4].isu; in_pc = 32'h800;
    @(negedge clk);
    in_valid = 1'b0;
    n_tests++; if (out_pc !== 32'h800 || imm !== 32'h12345000 || count !== 2'd1) begin
      n_fail++; $display("FAIL mid_reset_push: got pc=%h imm=%h count=%0d want 800/12345000/1", out_pc, imm, count);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //        isu           pc       rd     rs1    rs2    f3    f7      op      imm           fmt   ill
    vec[0] = '{32'hFFF10093, 32'h100, 5'd1,  5'd2,  5'd31, 3'd0, 7'h7F, 7'h13, 32'hFFFFFFFF, 3'd1, 1'b0};
    vec[1] = '{32'h00532423, 32'h104, 5'd8,  5'd6,  5'd5,  3'd2, 7'h00, 7'h23, 32'h00000008, 3'd2, 1'b0};
    vec[2] = '{32'hFE000E63, 32'h108, 5'd28, 5'd0,  5'd0,  3'd0, 7'h7F, 7'h63, 32'hFFFFF7FC, 3'd3, 1'b0};
    vec[3] = '{32'hFE000EE3, 32'h10C, 5'd29, 5'd0,  5'd0,  3'd0, 7'h7F, 7'h63, 32'hFFFFFFFC, 3'd3, 1'b0};
    vec[4] = '{32'h123451B7, 32'h110, 5'd3,  5'd8,  5'd3,  3'd5, 7'h09, 7'h37, 32'h12345000, 3'd4, 1'b0};
    vec[5] = '{32'h008000EF, 32'h114, 5'd1,  5'd0,  5'd8,  3'd0, 7'h00, 7'h6F, 32'h00000008, 3'd5, 1'b0};
    vec[6] = '{32'h00000033, 32'h118, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 7'h33, 32'h00000000, 3'd0, 1'b0};
    vec[7] = '{32'h00000000, 32'h11C, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 7'h00, 32'h00000000, 3'd0, ILL_EN};
    vec[8] = '{32'hFFFFF097, 32'h120, 5'd1,  5'd31, 5'd31, 3'd7, 7'h7F, 7'h17, 32'hFFFFF000, 3'd4, 1'b0};

    test_reset();
    test_decode();
    test_full();
    test_back_to_back();
    test_flush();
    test_reset_mid();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
